// File: rtl/mux_sched_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the 4-way mux scheduler.
package mux_sched_pkg;
    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    function automatic logic [NREQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
        onehot2      = '0;
        onehot2[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping 3->0.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SEL_W-1:0]  enc;

    // Rotate so ptr lands at bit 0, pick the lowest set bit, then rotate the index back.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        valid = |rot;
        enc   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = SEL_W'(i);
        end
        idx = enc + ptr;
    end
endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner scheduler for the 8-bit 4:1 output mux, with one turnaround cycle between owners.
// Optional forced revoke after MAX_HOLD grant cycles is enabled by defining SCHED_TIMEOUT_EN.
module mux4_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] mux_s,
    output logic             mux_en,
    output logic             busy,
    output logic             timeout
);
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be >= 1");
    end

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]  mux_s_q, mux_s_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              mux_en_q, mux_en_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic              pick_valid;
    logic [SEL_W-1:0]  pick_idx;
    logic              force_revoke;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef SCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    assign force_revoke = (state_q == GRANT) && req[mux_s_q] &&
                          (hold_cnt_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        hold_cnt_d = '0;
        if (state_d == GRANT) begin
            if (state_q != GRANT)
                hold_cnt_d = HOLD_W'(1);
            else if (hold_cnt_q != HOLD_W'(MAX_HOLD))
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            else
                hold_cnt_d = hold_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_cnt_q <= '0;
        else        hold_cnt_q <= hold_cnt_d;
    end
`else
    assign force_revoke = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // IDLE and TURN arbitrate identically; an owner is never pre-empted by other requesters.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, TURN: state_d = pick_valid ? GRANT : IDLE;
            GRANT:      if (!req[mux_s_q] || force_revoke) state_d = TURN;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        mux_s_d   = mux_s_q;
        rr_ptr_d  = rr_ptr_q;
        timeout_d = 1'b0;
        mux_en_d  = (state_d == GRANT);
        busy_d    = (state_d != IDLE);
        if (state_q != GRANT && state_d == GRANT) begin
            gnt_d   = onehot2(pick_idx);
            mux_s_d = pick_idx;
        end
        // mux_s keeps the last owner through TURN so y does not glitch during handover.
        if (state_q == GRANT && state_d == TURN) begin
            gnt_d     = '0;
            rr_ptr_d  = mux_s_q + SEL_W'(1);
            timeout_d = force_revoke;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            mux_s_q   <= '0;
            rr_ptr_q  <= '0;
            mux_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            mux_s_q   <= mux_s_d;
            rr_ptr_q  <= rr_ptr_d;
            mux_en_q  <= mux_en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign mux_s   = mux_s_q;
    assign mux_en  = mux_en_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Self-checking bench for mux4_rr_scheduler: directed scenarios plus a randomized run against a behavioural model.
module tb_mux4_rr_scheduler;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] mux_s;
    logic       mux_en, busy, timeout;

    int total = 0;
    int bad = 0;

    // Reference model: who owns the mux, whether we are in the gap cycle, and where the search starts.
    int m_owner, m_last, m_ptr, m_held;
    bit m_turn, m_to;

    mux4_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .mux_s(mux_s), .mux_en(mux_en), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_turn = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        bit rel, found;
        m_to = 0;
        if (m_owner >= 0) begin
            rel = !r[m_owner];
`ifdef SCHED_TIMEOUT_EN
            if (!rel && m_held == MAX_HOLD) begin rel = 1; m_to = 1; end
`endif
            if (rel) begin
                m_ptr = (m_owner + 1) % 4; m_owner = -1; m_turn = 1;
            end else if (m_held < MAX_HOLD) m_held++;
        end else begin
            m_turn = 0;
            found = 0;
            for (int n = 0; n < 4; n++) begin
                if (!found && r[(m_ptr + n) % 4]) begin
                    found = 1; m_owner = (m_ptr + n) % 4; m_last = m_owner; m_held = 1;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    task automatic cyc(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst_n = 0; req = 4'b0000;
        @(negedge clk); rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 0; model_reset();
        #2;
        total++;
        if ({gnt, mux_s, mux_en, busy, timeout} !== 9'b0) begin
            bad++; $display("FAIL reset_state: got %b want 0", {gnt, mux_s, mux_en, busy, timeout});
        end
        @(negedge clk); rst_n = 1;
        cyc(4'b0100);
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL reset_first_grant: got %b want 0100", gnt); end
        cyc(4'b0000);
        cyc(4'b0100);
        total++;
        if (gnt !== 4'b0100 || mux_en !== 1'b1) begin
            bad++; $display("FAIL reset_pre_grant: got gnt=%b en=%b want 0100/1", gnt, mux_en);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (gnt !== 4'b0000 || mux_en !== 1'b0) begin
            bad++; $display("FAIL reset_async_drop: got gnt=%b en=%b want 0000/0", gnt, mux_en);
        end
        @(negedge clk); rst_n = 1; model_reset();
        cyc(4'b1111);
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_ptr_zero: got %b want 0001", gnt); end
        cyc(4'b0000); cyc(4'b0000);
    endtask

    task automatic test_single();
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100);
            total++;
            if (gnt !== 4'b0100 || mux_s !== 2'b10 || mux_en !== 1'b1 || busy !== 1'b1) begin
                bad++; $display("FAIL single_grant[%0d]: got gnt=%b s=%b en=%b busy=%b", i, gnt, mux_s, mux_en, busy);
            end
        end
        cyc(4'b0000);
        total++;
        if (gnt !== 4'b0000 || mux_en !== 1'b0 || busy !== 1'b1 || mux_s !== 2'b10) begin
            bad++; $display("FAIL single_turn: got gnt=%b en=%b busy=%b s=%b", gnt, mux_en, busy, mux_s);
        end
        cyc(4'b0000);
        total++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            bad++; $display("FAIL single_idle: got busy=%b gnt=%b want 0/0000", busy, gnt);
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                cyc(4'b1111);
                total++;
                if (gnt !== 4'(1 << k)) begin
                    bad++; $display("FAIL fair_owner%0d_c%0d: got %b want %b", k, c, gnt, 4'(1 << k));
                end
            end
            cyc(4'b1111 & ~4'(1 << k));
            total++;
            if (gnt !== 4'b0000 || busy !== 1'b1) begin
                bad++; $display("FAIL fair_turn%0d: got gnt=%b busy=%b want 0000/1", k, gnt, busy);
            end
        end
        cyc(4'b1111);
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL fair_wrap: got %b want 0001", gnt); end
    endtask

    task automatic test_race();
        logic [3:0] exp [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b1000};
        logic [3:0] stim [4] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(stim[i]);
            total++;
            if (gnt !== exp[i] || $countones(gnt) > 1) begin
                bad++; $display("FAIL race_step%0d: got %b want %b", i, gnt, exp[i]);
            end
        end
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] exp [11] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0010};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0010);
            total++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                bad++; $display("FAIL to_hold%0d: got gnt=%b to=%b", i, gnt, timeout);
            end
        end
        cyc(4'b0010);
        total++;
        if (gnt !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL to_revoke: got gnt=%b to=%b busy=%b want 0000/1/1", gnt, timeout, busy);
        end
        cyc(4'b0010);
        total++;
        if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            bad++; $display("FAIL to_regrant: got gnt=%b to=%b want 0010/0", gnt, timeout);
        end
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            cyc(4'b1010);
            total++;
            if (gnt !== exp[i] || timeout !== (exp[i] == 4'b0000)) begin
                bad++; $display("FAIL to_alt%0d: got gnt=%b to=%b want %b", i, gnt, timeout, exp[i]);
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        int errs = 0;
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            cyc(4'b0001);
            if (gnt !== 4'b0001 || timeout !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL hold_forever: got %0d bad cycles want 0", errs); end
    endtask
`endif

    task automatic test_random();
        logic [3:0] r = 4'b0000;
        logic [3:0] flip;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            flip = '0;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
            r = r ^ flip;
            cyc(r);
            total++;
            if (gnt !== exp_gnt() || mux_s !== 2'(m_last) || mux_en !== (m_owner >= 0) ||
                busy !== (m_owner >= 0 || m_turn) || timeout !== m_to) begin
                bad++;
                $display("FAIL rand%0d: req=%b got gnt=%b s=%0d en=%b busy=%b to=%b want gnt=%b s=%0d en=%b busy=%b to=%b",
                         i, r, gnt, mux_s, mux_en, busy, timeout, exp_gnt(), m_last,
                         m_owner >= 0, m_owner >= 0 || m_turn, m_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_race();
`ifdef SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
